nios2os_nios2_qsys_div_cell: RTL and testbench

// - Iterative 32/32 integer divider: the inverse companion of the CPU multiply cell, serving DIV/DIVU.
// - Radix-2 restoring algorithm, one quotient bit per clock; start/done handshake to the A-stage stall logic.
// - Produces quotient and remainder (C truncation semantics) plus a divide-by-zero flag.

---
 rtl/nios2os_div_pkg.sv | 15 +
 rtl/nios2os_div_step.sv | 22 ++
 rtl/nios2os_nios2_qsys_div_cell.sv | 125 ++++++++++++
 tb/tb_nios2os_nios2_qsys_div_cell.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nios2os_div_pkg.sv
// Shared types and sizing for the iterative 32/32 divider cell.
// Other blocks import this to agree on state encoding and widths.
package nios2os_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/nios2os_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module nios2os_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem_in,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_out,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;

  assign w_shifted = {i_rem_in, i_dvd_msb};
  assign o_q_bit   = (w_shifted >= {1'b0, i_divisor});
  // The remainder stays below the divisor, so a fitting difference always
  // lands in WIDTH bits and the modular subtraction is exact.
  assign o_rem_out = o_q_bit ? (w_shifted[WIDTH-1:0] - i_divisor)
                             : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/nios2os_nios2_qsys_div_cell.sv
// Iterative DIV/DIVU unit: operands are reduced to magnitudes, divided one
// bit per clock, and the signs are restored in a single fixup cycle.
module nios2os_nios2_qsys_div_cell
  import nios2os_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             A_div_start,
  input  logic             A_div_signed,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quot,
  output logic [WIDTH-1:0] A_div_rem,
  output logic             A_div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_by_zero;

  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_src1_mag;
  logic [WIDTH-1:0] w_src2_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;

  assign w_neg1     = A_div_signed & A_div_src1[WIDTH-1];
  assign w_neg2     = A_div_signed & A_div_src2[WIDTH-1];
  assign w_src1_mag = w_neg1 ? -A_div_src1 : A_div_src1;
  assign w_src2_mag = w_neg2 ? -A_div_src2 : A_div_src2;

  nios2os_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem_in  (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem_out (w_step_rem),
    .o_q_bit   (w_step_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (A_div_start) begin
            r_dvd    <= w_src1_mag;
            r_dvs    <= w_src2_mag;
            r_rem    <= '0;
            r_sign_q <= A_div_signed & (A_div_src1[WIDTH-1] ^ A_div_src2[WIDTH-1]);
            r_sign_r <= w_neg1;
            r_zero   <= (w_src2_mag == '0);
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= (w_src2_mag == '0) ? FIXUP : CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        CALC: begin
          // Quotient bits fill r_dvd from the bottom as dividend bits leave the top.
          r_rem <= w_step_rem;
          r_dvd <= {r_dvd[WIDTH-2:0], w_step_q};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_state <= FIXUP;
          end
        end
        FIXUP: begin
          // On a zero divisor r_dvd still holds |src1|; re-signing it returns src1.
          r_quot    <= r_zero ? '1 : (r_sign_q ? -r_dvd : r_dvd);
          r_rem_out <= r_zero ? (r_sign_r ? -r_dvd : r_dvd)
                              : (r_sign_r ? -r_rem : r_rem);
          r_by_zero <= r_zero;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign A_div_busy    = r_busy;
  assign A_div_done    = r_done;
  assign A_div_quot    = r_quot;
  assign A_div_rem     = r_rem_out;
  assign A_div_by_zero = r_by_zero;

endmodule

// File: tb/tb_nios2os_nios2_qsys_div_cell.sv
// Randomised and directed checks of the divider against C-style integer
// division computed with 64-bit arithmetic in the bench.
module tb_nios2os_nios2_qsys_div_cell;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         A_div_start = 1'b0;
  logic         A_div_signed = 1'b0;
  logic [W-1:0] A_div_src1 = '0;
  logic [W-1:0] A_div_src2 = '0;
  logic         A_div_busy;
  logic         A_div_done;
  logic [W-1:0] A_div_quot;
  logic [W-1:0] A_div_rem;
  logic         A_div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  nios2os_nios2_qsys_div_cell #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .A_div_start   (A_div_start),
    .A_div_signed  (A_div_signed),
    .A_div_src1    (A_div_src1),
    .A_div_src2    (A_div_src2),
    .A_div_busy    (A_div_busy),
    .A_div_done    (A_div_done),
    .A_div_quot    (A_div_quot),
    .A_div_rem     (A_div_rem),
    .A_div_by_zero (A_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on sign-extended 64-bit values.
  function automatic void model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Call just after a falling edge; returns just after the accepting edge.
  task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    A_div_signed = s;
    A_div_src1   = a;
    A_div_src2   = b;
    A_div_start  = 1'b1;
    @(posedge clk);
    #1;
    A_div_start  = 1'b0;
    A_div_src1   = $urandom;
    A_div_src2   = $urandom;
    A_div_signed = $urandom_range(0, 1);
  endtask

  // Waits for done (bounded), optionally pulsing a junk start at cycle 'poke'.
  task automatic wait_done(input string tag, input bit s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int poke);
    logic [W-1:0] eq, er;
    bit ez;
    int lat_exp, got_lat;
    model(s, a, b, eq, er, ez);
    lat_exp = (b == 0) ? 2 : W + 2;
    got_lat = -1;
    for (int lat = 1; lat <= W + 8; lat++) begin
      @(negedge clk);
      if (lat == poke) begin
        A_div_start = 1'b1;
        A_div_src1  = $urandom;
        A_div_src2  = $urandom_range(1, 5);
      end
      if (lat == poke + 1) A_div_start = 1'b0;
      if (A_div_done) begin
        got_lat = lat;
        break;
      end
      if (lat == 1 || lat == lat_exp - 1) check({tag, ".busy"}, 32'(A_div_busy), 32'd1);
    end
    A_div_start = 1'b0;
    check({tag, ".latency"}, 32'(got_lat), 32'(lat_exp));
    check({tag, ".quot"}, A_div_quot, eq);
    check({tag, ".rem"}, A_div_rem, er);
    check({tag, ".by_zero"}, 32'(A_div_by_zero), 32'(ez));
    check({tag, ".busy_done"}, 32'(A_div_busy), 32'd0);
    $display("op %s s=%0d %h / %h -> q=%h r=%h z=%0d lat=%0d", tag, s, a, b,
             A_div_quot, A_div_rem, A_div_by_zero, got_lat);
  endtask

  task automatic run(input string tag, input bit s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int poke);
    issue(s, a, b);
    wait_done(tag, s, a, b, poke);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, hq, hr;
    bit s;
    int gap, ndone;

    repeat (3) @(negedge clk);
    check("reset.quot", A_div_quot, '0);
    check("reset.rem", A_div_rem, '0);
    check("reset.flags", {29'd0, A_div_busy, A_div_done, A_div_by_zero}, '0);
    reset_n = 1'b1;
    @(negedge clk);

    run("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
    run("div_m7_2", 1'b1, -32'sd7, 32'd2, 0);
    run("div_7_m2", 1'b1, 32'd7, -32'sd2, 0);
    run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 0);
    run("div_m5_by0", 1'b1, -32'sd5, 32'd0, 0);
    run("busy_ignore", 1'b0, 32'd1000, 32'd9, 5);
    // Back-to-back: the second start lands in the DONE cycle of the first.
    run("b2b_first", 1'b1, 32'hDEAD_BEEF, 32'd13, 0);
    run("b2b_second", 1'b0, 32'hCAFE_F00D, 32'd77, 0);

    // Reset part-way through an operation must abort it silently.
    issue(1'b0, 32'hFFFF_1234, 32'd3);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #2;
    check("midrst.quot", A_div_quot, '0);
    check("midrst.rem", A_div_rem, '0);
    check("midrst.flags", {30'd0, A_div_busy, A_div_done}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (W + 6) begin
      @(negedge clk);
      if (A_div_done) ndone++;
    end
    check("midrst.no_done", 32'(ndone), 32'd0);
    run("after_rst", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = $urandom_range(0, 1) ? 32'd1 : 32'hFFFF_FFFF;
        2: begin a = 32'h8000_0000; b = $urandom; end
        3, 4, 5: b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      gap = $urandom_range(0, 2);
      hq = A_div_quot;
      hr = A_div_rem;
      repeat (gap) @(negedge clk);
      if (gap > 0) begin
        check("hold.quot", A_div_quot, hq);
        check("hold.rem", A_div_rem, hr);
        check("hold.done", 32'(A_div_done), 32'd0);
      end
      run($sformatf("rnd%0d", i), s, a, b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
